// File: rtl/counter_pkg.sv
// counter_pkg: shared counter width, verdict encoding and up/down step classifier
package counter_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {V_INCR, V_DECR, V_ERROR} verdict_t;

    // incr wins over decr; 15->0 and 0->15 are deliberately treated as errors
    function automatic verdict_t step_verdict(input logic [CNT_W-1:0] prev, input logic [CNT_W-1:0] d);
        if (prev != '1 && d == CNT_W'(prev + 1'b1)) return V_INCR;
        if (prev != '0 && d == CNT_W'(prev - 1'b1)) return V_DECR;
        return V_ERROR;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx
);

    logic w_found;

    // first requester at or after the pointer wins
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && i_req[(int'(i_ptr) + k) % N]) begin
                w_found                          = 1'b1;
                o_grant[(int'(i_ptr) + k) % N]   = 1'b1;
                o_idx                            = PW'((int'(i_ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/counter_stream_sched.sv
// counter_stream_sched: round-robin shared step checker for several 4-bit counter streams
module counter_stream_sched
    import counter_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int ERR_LIMIT = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       req_valid,
    input  logic [CNT_W*NUM_CH-1:0] req_data,
    output logic [NUM_CH-1:0]       req_ready,
    input  logic [NUM_CH-1:0]       clear_ch,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2:0]              out_ch,
    output logic                    out_incr,
    output logic                    out_decr,
    output logic                    out_error,
    output logic [NUM_CH-1:0]       locked
);

    localparam int PW = $clog2(NUM_CH);

    logic [CNT_W-1:0]  r_prev [NUM_CH];
    logic [CNT_W-1:0]  r_ecnt [NUM_CH];
    logic [NUM_CH-1:0] r_locked;
    logic [PW-1:0]     r_ptr;
    logic              r_out_valid;
    logic [2:0]        r_out_ch;
    logic              r_incr, r_decr, r_error;

    logic [NUM_CH-1:0] w_elig;
    logic [NUM_CH-1:0] w_grant;
    logic [PW-1:0]     w_idx;
    logic              w_stall;
    logic              w_xfer;
    logic [CNT_W-1:0]  w_d;
    logic [CNT_W-1:0]  w_ecnt_nx;
    verdict_t          w_verdict;

    assign w_elig    = req_valid & ~r_locked & ~clear_ch;
    assign w_stall   = r_out_valid & ~out_ready;
    assign w_xfer    = (|w_grant) & ~w_stall;
    assign w_d       = req_data[w_idx*CNT_W +: CNT_W];
    assign w_verdict = step_verdict(r_prev[w_idx], w_d);
    assign w_ecnt_nx = r_ecnt[w_idx] + 1'b1;

    // ready is suppressed while reset is held so nothing looks accepted during reset
    assign req_ready = w_grant & {NUM_CH{~w_stall & reset}};
    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_incr  = r_incr;
    assign out_decr  = r_decr;
    assign out_error = r_error;
    assign locked    = r_locked;

    rr_arbiter #(.N(NUM_CH), .PW(PW)) u_arb (
        .i_req   (w_elig),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    // per-channel context: clear beats the (impossible) same-cycle transfer on that channel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_prev[i] <= '0;
                r_ecnt[i] <= '0;
            end
            r_locked <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clear_ch[i]) begin
                    r_prev[i]   <= '0;
                    r_ecnt[i]   <= '0;
                    r_locked[i] <= 1'b0;
                end else if (w_xfer && w_idx == PW'(i)) begin
                    r_prev[i] <= w_d;
                    r_ecnt[i] <= (w_verdict == V_ERROR) ? w_ecnt_nx : '0;
                    if (w_verdict == V_ERROR && w_ecnt_nx == CNT_W'(ERR_LIMIT))
                        r_locked[i] <= 1'b1;
                end
            end
        end
    end

    // pointer moves past the served channel only when something transfers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_ptr <= '0;
        else if (w_xfer)
            r_ptr <= (w_idx == PW'(NUM_CH - 1)) ? '0 : w_idx + 1'b1;
    end

    // verdict register: load on transfer, hold on stall, drain when accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_incr      <= 1'b0;
            r_decr      <= 1'b0;
            r_error     <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_ch    <= 3'(w_idx);
            r_incr      <= (w_verdict == V_INCR);
            r_decr      <= (w_verdict == V_DECR);
            r_error     <= (w_verdict == V_ERROR);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
